// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs byte/half/word accesses over a req/ready bus and stalls the pipe.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op_type,
  input  logic [31:0] alu_result,
  input  logic [4:0]  write_reg_address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [3:0]  op_type_next,
  output logic [31:0] read_data_next,
  output logic [31:0] alu_result_next,
  output logic [4:0]  write_reg_address_next,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        misalign,
  output logic [31:0] bad_addr,
  output logic        bus_error
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        misalign_q, misalign_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_mem, aligned, start, drop;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        timeout;
  logic        timed_out_q;

  always_comb begin
    is_mem = mem_read | mem_write;
    unique case (mem_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~alu_result[0];
      default: aligned = (alu_result[1:0] == 2'b00);
    endcase
    start = (state_q == StIdle) && is_mem && aligned;
    drop  = (state_q == StIdle) && is_mem && !aligned;
  end

  // Store lane steering, little-endian.
  always_comb begin
    unique case (mem_size)
      2'd0: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{write_data[7:0]}};
      end
      2'd1: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{write_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = write_data;
      end
    endcase
  end

  // Load formatting from the captured bus word; the instruction is still held on the inputs.
  always_comb begin
    unique case (alu_result[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = alu_result[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (mem_size)
      2'd0:    ld_data = mem_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = mem_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timed_out_d;
  logic            bus_error_q, bus_error_d;

  always_comb begin
    // Counter is zero on entry to WAIT and counts completed WAIT cycles.
    cnt_d       = (state_q == StWait) ? cnt_q + 1'b1 : '0;
    timeout     = (state_q == StWait) && !mem_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    bus_error_d = timeout;
    timed_out_d = timeout ? 1'b1 : ((state_q == StDone) ? 1'b0 : timed_out_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign timeout     = 1'b0;
  assign timed_out_q = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // State register and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      misalign_q  <= 1'b0;
      bad_addr_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      misalign_q  <= misalign_d;
      bad_addr_q  <= bad_addr_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    misalign_d  = 1'b0;
    bad_addr_d  = bad_addr_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StWait;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write;
          mem_addr_d  = {alu_result[31:2], 2'b00};
          mem_be_d    = st_be;
          mem_wdata_d = st_wdata;
        end else if (drop) begin
          misalign_d = 1'b1;
          bad_addr_d = alu_result;
        end
      end
      StWait: begin
        if (mem_ready) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = '0;
          rdata_d   = mem_rdata;
        end else if (timeout) begin
          state_d    = StDone;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = '0;
          bad_addr_d = alu_result;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs to MEM2WB and the pipeline stall.
  always_comb begin
    op_type_next           = op_type;
    alu_result_next        = alu_result;
    write_reg_address_next = write_reg_address;
    read_data_next         = '0;
    stall                  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (drop) begin
          op_type_next           = '0;
          write_reg_address_next = '0;
        end
        stall = start;
      end
      StWait: stall = 1'b1;
      StDone: begin
        if (timed_out_q) begin
          op_type_next           = '0;
          write_reg_address_next = '0;
        end else if (mem_read) begin
          read_data_next = ld_data;
        end
      end
      default: stall = 1'b0;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign misalign  = misalign_q;
  assign bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; the timeout case is built only with LSU_TIMEOUT_EN.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op_type;
  logic [31:0] alu_result;
  logic [4:0]  write_reg_address;
  logic [31:0] write_data;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [3:0]  op_type_next;
  logic [31:0] read_data_next, alu_result_next;
  logic [4:0]  write_reg_address_next;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        misalign;
  logic [31:0] bad_addr;
  logic        bus_error;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .op_type                (op_type),
    .alu_result             (alu_result),
    .write_reg_address      (write_reg_address),
    .write_data             (write_data),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_size               (mem_size),
    .mem_unsigned           (mem_unsigned),
    .op_type_next           (op_type_next),
    .read_data_next         (read_data_next),
    .alu_result_next        (alu_result_next),
    .write_reg_address_next (write_reg_address_next),
    .stall                  (stall),
    .mem_req                (mem_req),
    .mem_we                 (mem_we),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .mem_be                 (mem_be),
    .mem_ready              (mem_ready),
    .mem_rdata              (mem_rdata),
    .misalign               (misalign),
    .bad_addr               (bad_addr),
    .bus_error              (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    op_type           = 4'd0;
    alu_result        = 32'h0;
    write_reg_address = 5'd0;
    write_data        = 32'h0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_size          = 2'd0;
    mem_unsigned      = 1'b0;
    mem_ready         = 1'b0;
  endtask

  // One complete access; nwait is the number of WAIT cycles including the ready one.
  task automatic access(input string tag, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int nwait, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
    int stalls = 0;
    op_type           = 4'd3;
    alu_result        = addr;
    write_reg_address = 5'd9;
    write_data        = wd;
    mem_read          = !wr;
    mem_write         = wr;
    mem_size          = size;
    mem_unsigned      = uns;
    #1;
    stalls += int'(stall);
    chk({tag, ":req_idle"}, 32'(mem_req), 32'd0);
    tick();
    chk({tag, ":req"}, 32'(mem_req), 32'd1);
    chk({tag, ":we"}, 32'(mem_we), 32'(wr));
    chk({tag, ":addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ":be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, ":wdata"}, mem_wdata, exp_wdata);
    for (int i = 1; i <= nwait; i++) begin
      chk({tag, ":req_held"}, 32'(mem_req), 32'd1);
      stalls += int'(stall);
      mem_ready = (i == nwait);
      mem_rdata = rdata;
      tick();
    end
    mem_ready = 1'b0;
    chk({tag, ":stall_done"}, 32'(stall), 32'd0);
    chk({tag, ":rd"}, read_data_next, exp_rd);
    chk({tag, ":req_done"}, 32'(mem_req), 32'd0);
    chk({tag, ":be_done"}, 32'(mem_be), 32'd0);
    chk({tag, ":op"}, 32'(op_type_next), 32'd3);
    chk({tag, ":wra"}, 32'(write_reg_address_next), 32'd9);
    chk({tag, ":stall_cycles"}, 32'(stalls), 32'(nwait + 1));
    tick();
    set_nop();
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_rdata = 32'h0;
    set_nop();
    #2;
    chk("rst:req", 32'(mem_req), 32'd0);
    chk("rst:we", 32'(mem_we), 32'd0);
    chk("rst:addr", mem_addr, 32'd0);
    chk("rst:wdata", mem_wdata, 32'd0);
    chk("rst:be", 32'(mem_be), 32'd0);
    chk("rst:misalign", 32'(misalign), 32'd0);
    chk("rst:bad_addr", bad_addr, 32'd0);
    chk("rst:bus_error", 32'(bus_error), 32'd0);
    chk("rst:stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Non-memory op passes straight through.
    op_type           = 4'd1;
    alu_result        = 32'h1234;
    write_reg_address = 5'd5;
    #1;
    chk("add:op", 32'(op_type_next), 32'd1);
    chk("add:alu", alu_result_next, 32'h1234);
    chk("add:wra", 32'(write_reg_address_next), 32'd5);
    chk("add:rd", read_data_next, 32'd0);
    chk("add:stall", 32'(stall), 32'd0);
    tick();
    chk("add:req", 32'(mem_req), 32'd0);
    set_nop();

    access("lw",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'hF, 32'h0, 32'hDEADBEEF);
    access("lb",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 1, 4'h8, 32'h0, 32'hFFFFFF80);
    access("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 1, 4'h8, 32'h0, 32'h00000080);
    access("lh",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FFFF7F, 1, 4'hC, 32'h0, 32'hFFFF80FF);
    access("lhu", 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h12348001, 2, 4'h3, 32'h0, 32'h00008001);
    access("sb",  1'b1, 2'd0, 1'b0, 32'h101, 32'hAB, 32'h0, 3, 4'h2, 32'hABABABAB, 32'h0);
    access("sh",  1'b1, 2'd1, 1'b0, 32'h102, 32'h1234CDEF, 32'h0, 1, 4'hC, 32'hCDEFCDEF, 32'h0);
    access("sw",  1'b1, 2'd2, 1'b0, 32'h200, 32'h12345678, 32'h0, 1, 4'hF, 32'h12345678, 32'h0);

    // Misaligned word load is dropped as a bubble.
    op_type           = 4'd3;
    alu_result        = 32'h102;
    write_reg_address = 5'd9;
    mem_read          = 1'b1;
    mem_size          = 2'd2;
    #1;
    chk("mis:op", 32'(op_type_next), 32'd0);
    chk("mis:wra", 32'(write_reg_address_next), 32'd0);
    chk("mis:rd", read_data_next, 32'd0);
    chk("mis:stall", 32'(stall), 32'd0);
    tick();
    set_nop();
    chk("mis:pulse", 32'(misalign), 32'd1);
    chk("mis:bad_addr", bad_addr, 32'h102);
    chk("mis:req", 32'(mem_req), 32'd0);
    tick();
    chk("mis:pulse_end", 32'(misalign), 32'd0);

    // A stray ready outside WAIT has no effect.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("stray:req", 32'(mem_req), 32'd0);
    chk("stray:stall", 32'(stall), 32'd0);

`ifdef LSU_TIMEOUT_EN
    op_type           = 4'd3;
    alu_result        = 32'h300;
    write_reg_address = 5'd9;
    mem_read          = 1'b1;
    mem_size          = 2'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to:wait_stall", 32'(stall), 32'd1);
      chk("to:no_err", 32'(bus_error), 32'd0);
      tick();
    end
    chk("to:bus_error", 32'(bus_error), 32'd1);
    chk("to:bad_addr", bad_addr, 32'h300);
    chk("to:req", 32'(mem_req), 32'd0);
    chk("to:op", 32'(op_type_next), 32'd0);
    chk("to:wra", 32'(write_reg_address_next), 32'd0);
    chk("to:stall", 32'(stall), 32'd0);
    tick();
    set_nop();
    chk("to:pulse_end", 32'(bus_error), 32'd0);
    tick();
`endif

    // Reset in the middle of WAIT abandons the access.
    op_type           = 4'd3;
    alu_result        = 32'h400;
    write_reg_address = 5'd9;
    mem_read          = 1'b1;
    mem_size          = 2'd2;
    tick();
    chk("rstw:req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw:req", 32'(mem_req), 32'd0);
    set_nop();
    #1;
    chk("rstw:idle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstw:req_after", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit of the MEM stage. Sits between the EX/MEM pipeline register and the MEM2WB register. It runs byte, halfword and word accesses to the data-memory bus through a request/ready handshake and stalls the pipeline until the access completes. It produces the next-state inputs of MEM2WB: op type, formatted read data, ALU result and destination register.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles waited for `mem_ready` (used only with `LSU_TIMEOUT_EN`).
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `op_type`, `alu_result`, `write_reg_address`  in  4/32/5  from EX/MEM. `alu_result` is the effective address for memory ops.
- `write_data`  in  32  store data (rt value).
- `mem_read`, `mem_write`  in  1/1  load/store instruction. Both low means a non-memory op.
- `mem_size`  in  2  0=byte, 1=halfword, 2=word (3 is treated as word).
- `mem_unsigned`  in  1  zero-extend loads (lbu/lhu).
- `op_type_next`, `read_data_next`, `alu_result_next`, `write_reg_address_next`  out  4/32/32/5  to MEM2WB.
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM2WB input meaning.
- `mem_req`, `mem_we`  out  1/1  bus request / write.
- `mem_addr`  out  32  word-aligned address (`[1:0]`=0).
- `mem_wdata`, `mem_be`  out  32/4  store data lanes / byte enables.
- `mem_ready`  in  1  access done this cycle; `mem_rdata` valid.
- `mem_rdata`  in  32  load word.
- `misalign`  out  1  one-cycle pulse: misaligned access dropped.
- `bad_addr`  out  32  address of last misaligned/timed-out access.
- `bus_error`  out  1  one-cycle pulse: timeout (only with `LSU_TIMEOUT_EN`).

## Operation
- Reset values:
  - state IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
  - `misalign`=0, `bus_error`=0, `bad_addr`=0, internal load buffer 0.
  - `stall` and `*_next` follow the combinational rules below with state=IDLE.
- Non-memory op in IDLE:
  - Combinational pass-through: `op_type_next`=`op_type`, `alu_result_next`=`alu_result`, `write_reg_address_next`=`write_reg_address`.
  - `read_data_next`=0, `stall`=0.
- Alignment: halfword needs `addr[0]`=0; word needs `addr[1:0]`=0.
- Misaligned memory op in IDLE:
  - No bus access.
  - `misalign` pulses next cycle; `bad_addr` latched.
  - Outputs present a bubble: op_type 0, write_reg_address 0, read_data 0. `stall`=0.
- Aligned memory op in IDLE (the start condition):
  - `stall`=1 combinationally.
  - At the edge: register `mem_req`=1, `mem_we`=`mem_write`, `mem_addr`={`addr[31:2]`,2'b00}, `be`, `wdata`; go to WAIT.
- Store lanes, little-endian:
  - Byte: `be`=1<<`addr[1:0]`, `wdata`={4{wd[7:0]}}.
  - Half: `be`=`addr[1]`?4'b1100:4'b0011, `wdata`={2{wd[15:0]}}.
  - Word: `be`=4'b1111, `wdata`=wd.
- WAIT: `stall`=1, request held stable.
  - On `mem_ready`: drop `mem_req`/`mem_we`/`mem_be` to 0, capture `mem_rdata` into the buffer, go to DONE.
- DONE:
  - `stall`=0, pass-through of `op_type`/`alu_result`/`write_reg_address`.
  - `read_data_next`: for loads, the byte/half selected by `addr[1:0]`/`addr[1]`, sign- or zero-extended per `mem_unsigned`; for stores, 0.
  - Next edge returns to IDLE. DONE never re-starts the instruction still shown on the inputs.
- `mem_ready` outside WAIT is ignored.
- Async reset mid-access abandons the bus transaction; the memory model must tolerate a dropped `mem_req`.

## Timing
- Memory op latency: 1 cycle + bus wait + 1 cycle.
  - Minimum 3 cycles (IDLE, WAIT with `ready`, DONE); `stall` is high for the first 2.
  - MEM2WB captures at the end of DONE.
- Non-memory ops and misaligned ops: 0 added cycles.
- Back-to-back memory ops: the second starts in the IDLE cycle after DONE; no bubble beyond that.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter, cleared on entry to WAIT, counts WAIT cycles.
  - If it reaches `TIMEOUT_CYCLES` without `mem_ready`:
    - Drop `mem_req`, latch `bad_addr`, pulse `bus_error`.
    - Go to DONE, which outputs a bubble (op_type 0, write_reg_address 0).
  - `mem_ready` in the same cycle as the limit wins.
- Undefined: no counter. WAIT lasts indefinitely; `bus_error` is tied to 0.

## Test plan
- Add op (`op_type`=1, `alu_result`=0x1234, reg 5) -> same cycle: `*_next` equal inputs, `stall`=0, `mem_req` never high.
- lw 0x100 with `mem_ready` on the first WAIT cycle, `mem_rdata`=0xDEADBEEF -> `stall` high 2 cycles, `mem_addr`=0x100, `read_data_next`=0xDEADBEEF in DONE.
- lb 0x103 with `rdata`=0x80FF_FF7F -> 0xFFFFFF80; lbu -> 0x00000080; lh 0x102 -> 0xFFFF80FF.
- sb 0x101 with `wd`=0xAB -> `mem_be`=4'b0010, `mem_wdata`=0xABABABAB, `mem_we`=1; `ready` delayed 3 cycles -> `stall` high 4 cycles.
- lw 0x102 -> `misalign` pulse, `bad_addr`=0x102, no `mem_req`, `op_type_next`=0, `stall`=0.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `ready` never -> `bus_error` pulse after 4 WAIT cycles, bubble out. `rst_n` low during WAIT -> `mem_req`=0 immediately, state IDLE.
